p09_vga_timing_gen: RTL and testbench

Parametrised raster timing generator for the p09 video path. It replaces the fixed 640x480@60 counter with one whose front porch, sync, back porch, active extents and sync polarities are all set by parameters. It adds a pixel clock-enable so it can run from a faster system clock, and an 8-bit frame counter. An optional fetch-ahead position port lets pipelined pixel sources (tile/sprite lookups) issue reads ahead of the beam. It sits between the clock/reset logic and the game renderer; all renderer timing derives from its outputs.

---
 rtl/p09_vga_timing_gen_if.sv | 34 +++
 rtl/p09_vga_timing_gen.sv | 148 ++++++++++++++
 tb/tb_p09_vga_timing_gen.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p09_vga_timing_gen_if.sv
// Raster timing bundle: the pixel tick enable goes in; beam position, flags, sync and pulses come out.
interface p09_vga_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10
);
    logic          ce;
    logic          hsync;
    logic          vsync;
    logic          hactive;
    logic          vactive;
    logic          active;
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic          line_pulse;
    logic          frame_pulse;
    logic [7:0]    frame_count;
    logic [HW-1:0] fetch_hpos;
    logic [VW-1:0] fetch_vpos;
    logic          fetch_active;

    modport master (
        input  ce,
        output hsync, vsync, hactive, vactive, active, hpos, vpos,
               line_pulse, frame_pulse, frame_count,
               fetch_hpos, fetch_vpos, fetch_active
    );

    modport slave (
        output ce,
        input  hsync, vsync, hactive, vactive, active, hpos, vpos,
               line_pulse, frame_pulse, frame_count,
               fetch_hpos, fetch_vpos, fetch_active
    );
endinterface

// File: rtl/p09_vga_timing_gen.sv
// Parametrised raster timing generator with pixel clock-enable and frame counter.
// Define P09_VGA_TIMING_FETCH_EN to build the fetch-ahead position port; otherwise it is tied to 0.
module p09_vga_timing_gen #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic H_POL       = 1'b0,
    parameter logic V_POL       = 1'b0,
    parameter int   HW          = 10,
    parameter int   VW          = 10,
    parameter int   FETCH_AHEAD = 2
) (
    input  logic                 clk,
    input  logic                 nRst,
    p09_vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    if (FETCH_AHEAD < 1 || FETCH_AHEAD >= H_ACTIVE ||
        (1 << HW) < H_TOTAL || (1 << VW) < V_TOTAL) begin : g_bad_config
        $error("p09_vga_timing_gen: illegal timing parameters");
    end

    function automatic logic h_active_at(input logic [HW-1:0] h);
        return int'(h) < H_ACTIVE;
    endfunction

    function automatic logic v_active_at(input logic [VW-1:0] v);
        return int'(v) < V_ACTIVE;
    endfunction

    function automatic logic h_sync_at(input logic [HW-1:0] h);
        return (int'(h) >= H_ACTIVE + H_FP) && (int'(h) < H_ACTIVE + H_FP + H_SYNC);
    endfunction

    function automatic logic v_sync_at(input logic [VW-1:0] v);
        return (int'(v) >= V_ACTIVE + V_FP) && (int'(v) < V_ACTIVE + V_FP + V_SYNC);
    endfunction

    function automatic logic [HW-1:0] h_step(input logic [HW-1:0] h);
        return (h == H_LAST) ? '0 : h + HW'(1);
    endfunction

    function automatic logic [VW-1:0] v_step(input logic [VW-1:0] v, input logic line_wrap);
        if (!line_wrap)
            return v;
        return (v == V_LAST) ? '0 : v + VW'(1);
    endfunction

    logic [HW-1:0] hpos_reg, hpos_next;
    logic [VW-1:0] vpos_reg, vpos_next;
    logic          hactive_reg, vactive_reg;
    logic          hsync_reg, vsync_reg;
    logic [7:0]    frame_count_reg;
    logic          line_pulse;
    logic          frame_pulse;

    always_comb begin
        hpos_next = hpos_reg;
        vpos_next = vpos_reg;
        if (vga.ce) begin
            hpos_next = h_step(hpos_reg);
            vpos_next = v_step(vpos_reg, hpos_reg == H_LAST);
        end
    end

    assign line_pulse  = vga.ce && (hpos_reg == H_LAST);
    assign frame_pulse = line_pulse && (vpos_reg == V_LAST);

    // Flags are decoded from the next position so they line up with the hpos/vpos they describe.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hpos_reg        <= '0;
            vpos_reg        <= '0;
            hactive_reg     <= 1'b1;
            vactive_reg     <= 1'b1;
            hsync_reg       <= ~H_POL;
            vsync_reg       <= ~V_POL;
            frame_count_reg <= '0;
        end else begin
            hpos_reg    <= hpos_next;
            vpos_reg    <= vpos_next;
            hactive_reg <= h_active_at(hpos_next);
            vactive_reg <= v_active_at(vpos_next);
            hsync_reg   <= h_sync_at(hpos_next) ? H_POL : ~H_POL;
            vsync_reg   <= v_sync_at(vpos_next) ? V_POL : ~V_POL;
            if (frame_pulse)
                frame_count_reg <= frame_count_reg + 8'd1;
        end
    end

    assign vga.hpos        = hpos_reg;
    assign vga.vpos        = vpos_reg;
    assign vga.hactive     = hactive_reg;
    assign vga.vactive     = vactive_reg;
    assign vga.active      = hactive_reg & vactive_reg;
    assign vga.hsync       = hsync_reg;
    assign vga.vsync       = vsync_reg;
    assign vga.line_pulse  = line_pulse;
    assign vga.frame_pulse = frame_pulse;
    assign vga.frame_count = frame_count_reg;

`ifdef P09_VGA_TIMING_FETCH_EN
    // The fetch position is a second beam counter started FETCH_AHEAD ticks ahead and stepped in lockstep.
    logic [HW-1:0] fetch_hpos_reg, fetch_hpos_next;
    logic [VW-1:0] fetch_vpos_reg, fetch_vpos_next;
    logic          fetch_active_reg;

    always_comb begin
        fetch_hpos_next = fetch_hpos_reg;
        fetch_vpos_next = fetch_vpos_reg;
        if (vga.ce) begin
            fetch_hpos_next = h_step(fetch_hpos_reg);
            fetch_vpos_next = v_step(fetch_vpos_reg, fetch_hpos_reg == H_LAST);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            fetch_hpos_reg   <= HW'(FETCH_AHEAD);
            fetch_vpos_reg   <= '0;
            fetch_active_reg <= 1'b1;
        end else begin
            fetch_hpos_reg   <= fetch_hpos_next;
            fetch_vpos_reg   <= fetch_vpos_next;
            fetch_active_reg <= h_active_at(fetch_hpos_next) && v_active_at(fetch_vpos_next);
        end
    end

    assign vga.fetch_hpos   = fetch_hpos_reg;
    assign vga.fetch_vpos   = fetch_vpos_reg;
    assign vga.fetch_active = fetch_active_reg;
`else
    assign vga.fetch_hpos   = '0;
    assign vga.fetch_vpos   = '0;
    assign vga.fetch_active = 1'b0;
`endif

endmodule

// File: tb/tb_p09_vga_timing_gen.sv
// Bench for p09_vga_timing_gen: a default 640x480 instance and a tiny 8x6 instance, checked against a position model.
module tb_p09_vga_timing_gen;

    localparam int A_HA = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
    localparam int A_VA = 480, A_VFP = 10, A_VS = 2,  A_VBP = 33;
    localparam int A_HT = 800, A_VT = 525;
    localparam int B_HA = 4, B_HFP = 1, B_HS = 2, B_HBP = 1;
    localparam int B_VA = 3, B_VFP = 1, B_VS = 1, B_VBP = 1;
    localparam int B_HT = 8, B_VT = 6;
    localparam int FA   = 2;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hact;
        logic       vact;
        logic       act;
        logic       hs;
        logic       vs;
        logic [7:0] fc;
        logic [9:0] fh;
        logic [9:0] fv;
        logic       fact;
    } snap_t;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    always #5 clk = ~clk;

    p09_vga_timing_gen_if #(.HW(10), .VW(10)) if_a ();
    p09_vga_timing_gen_if #(.HW(4),  .VW(3))  if_b ();

    p09_vga_timing_gen dut_a (
        .clk  (clk),
        .nRst (nRst),
        .vga  (if_a)
    );

    p09_vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .H_POL(1'b1), .V_POL(1'b1), .HW(4), .VW(3), .FETCH_AHEAD(FA)
    ) dut_b (
        .clk  (clk),
        .nRst (nRst),
        .vga  (if_b)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    snap_t      q_a[$];
    snap_t      q_b[$];
    logic [3:0] qp[$];
    logic [3:0] obs_p;
    int ma_h, ma_v, ma_fc, mb_h, mb_v, mb_fc;

    // Reference: every output follows directly from the beam position and the timing table.
    function automatic snap_t model_snap(input int h, v, fc, ha, hfp, hs, hbp, va, vfp, vs, vbp,
                                         input bit hpol, vpol, input int fa);
        snap_t s;
        int ht, vt, fh, fv;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        s = '0;
        s.h    = 10'(h);
        s.v    = 10'(v);
        s.hact = (h < ha);
        s.vact = (v < va);
        s.act  = (h < ha) && (v < va);
        s.hs   = (h >= ha + hfp && h < ha + hfp + hs) ? hpol : !hpol;
        s.vs   = (v >= va + vfp && v < va + vfp + vs) ? vpol : !vpol;
        s.fc   = 8'(fc);
`ifdef P09_VGA_TIMING_FETCH_EN
        fh = (h + fa) % ht;
        fv = (h + fa >= ht) ? (v + 1) % vt : v;
        s.fh   = 10'(fh);
        s.fv   = 10'(fv);
        s.fact = (fh < ha) && (fv < va);
`else
        fh = fa + ht + vt;
        fv = fh;
`endif
        return s;
    endfunction

    function automatic snap_t snap_a(input int h, v, fc);
        return model_snap(h, v, fc, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, 1'b0, 1'b0, FA);
    endfunction

    function automatic snap_t snap_b(input int h, v, fc);
        return model_snap(h, v, fc, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, 1'b1, 1'b1, FA);
    endfunction

    function automatic snap_t dut_snap_a();
        snap_t s;
        s.h = if_a.hpos; s.v = if_a.vpos;
        s.hact = if_a.hactive; s.vact = if_a.vactive; s.act = if_a.active;
        s.hs = if_a.hsync; s.vs = if_a.vsync; s.fc = if_a.frame_count;
        s.fh = if_a.fetch_hpos; s.fv = if_a.fetch_vpos; s.fact = if_a.fetch_active;
        return s;
    endfunction

    function automatic snap_t dut_snap_b();
        snap_t s;
        s.h = 10'(if_b.hpos); s.v = 10'(if_b.vpos);
        s.hact = if_b.hactive; s.vact = if_b.vactive; s.act = if_b.active;
        s.hs = if_b.hsync; s.vs = if_b.vsync; s.fc = if_b.frame_count;
        s.fh = 10'(if_b.fetch_hpos); s.fv = 10'(if_b.fetch_vpos); s.fact = if_b.fetch_active;
        return s;
    endfunction

    task automatic model_reset();
        ma_h = 0; ma_v = 0; ma_fc = 0;
        mb_h = 0; mb_v = 0; mb_fc = 0;
        q_a.delete(); q_b.delete(); qp.delete();
    endtask

    task automatic reset_dut();
        if_a.ce = 1'b0;
        if_b.ce = 1'b0;
        nRst = 1'b0;
        model_reset();
        @(posedge clk);
        #3 nRst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: drive ce, record the combinational pulses, push the expected post-edge state.
    task automatic tick(input bit ce_a, input bit ce_b);
        logic [3:0] ep;
        if_a.ce = ce_a;
        if_b.ce = ce_b;
        #2;
        obs_p = {if_a.line_pulse, if_a.frame_pulse, if_b.line_pulse, if_b.frame_pulse};
        ep[3] = ce_a && (ma_h == A_HT - 1);
        ep[2] = ep[3] && (ma_v == A_VT - 1);
        ep[1] = ce_b && (mb_h == B_HT - 1);
        ep[0] = ep[1] && (mb_v == B_VT - 1);
        qp.push_back(ep);
        if (ce_a) begin
            if (ep[2]) ma_fc = (ma_fc + 1) % 256;
            ma_h++;
            if (ma_h == A_HT) begin ma_h = 0; ma_v = (ma_v + 1) % A_VT; end
        end
        if (ce_b) begin
            if (ep[0]) mb_fc = (mb_fc + 1) % 256;
            mb_h++;
            if (mb_h == B_HT) begin mb_h = 0; mb_v = (mb_v + 1) % B_VT; end
        end
        q_a.push_back(snap_a(ma_h, ma_v, ma_fc));
        q_b.push_back(snap_b(mb_h, mb_v, mb_fc));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        snap_t ea, eb;
        if_a.ce = 1'b0;
        if_b.ce = 1'b0;
        nRst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        ea = snap_a(0, 0, 0);
        eb = snap_b(0, 0, 0);
        checks++;
        if (dut_snap_a() !== ea) begin
            failures++;
            $display("FAIL reset_a got=%h exp=%h", dut_snap_a(), ea);
        end
        checks++;
        if (dut_snap_b() !== eb) begin
            failures++;
            $display("FAIL reset_b got=%h exp=%h", dut_snap_b(), eb);
        end
        checks++;
        if ({if_a.line_pulse, if_a.frame_pulse, if_b.line_pulse, if_b.frame_pulse} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pulses got=%b exp=0000",
                     {if_a.line_pulse, if_a.frame_pulse, if_b.line_pulse, if_b.frame_pulse});
        end
        #3 nRst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dut_snap_a() !== ea) begin
            failures++;
            $display("FAIL reset_release_idle got=%h exp=%h", dut_snap_a(), ea);
        end
        $display("test_reset done checks=%0d", checks);
    endtask

    task automatic test_line_default();
        snap_t ea, eb;
        logic [3:0] ep;
        int hs_cnt, hs_min, hs_max, lp_first, lp_second, vs_low;
        reset_dut();
        hs_cnt = 0; hs_min = 9999; hs_max = -1; lp_first = -1; lp_second = -1; vs_low = 0;
        for (int i = 0; i < 1600; i++) begin
            tick(1'b1, 1'b0);
            ea = q_a.pop_front(); eb = q_b.pop_front(); ep = qp.pop_front();
            checks++;
            if (dut_snap_a() !== ea || dut_snap_b() !== eb || obs_p !== ep) begin
                failures++;
                $display("FAIL line_step i=%0d a=%h/%h b=%h/%h p=%b/%b",
                         i, dut_snap_a(), ea, dut_snap_b(), eb, obs_p, ep);
            end
            if (obs_p[3]) begin
                if (lp_first < 0) lp_first = i;
                else if (lp_second < 0) lp_second = i;
            end
            if (if_a.hsync === 1'b0) begin
                hs_cnt++;
                if (int'(if_a.hpos) < hs_min) hs_min = int'(if_a.hpos);
                if (int'(if_a.hpos) > hs_max) hs_max = int'(if_a.hpos);
            end
            if (if_a.vsync === 1'b0) vs_low++;
            if (failures > 20) break;
        end
        checks++;
        if (hs_cnt != 192 || hs_min != 656 || hs_max != 751) begin
            failures++;
            $display("FAIL hsync_window got cnt=%0d min=%0d max=%0d exp cnt=192 min=656 max=751",
                     hs_cnt, hs_min, hs_max);
        end
        checks++;
        if (lp_first != 799 || lp_second - lp_first != 800) begin
            failures++;
            $display("FAIL line_period got first=%0d period=%0d exp first=799 period=800",
                     lp_first, lp_second - lp_first);
        end
        checks++;
        if (vs_low != 0) begin
            failures++;
            $display("FAIL vsync_idle got low_cycles=%0d exp 0", vs_low);
        end
        $display("test_line_default done checks=%0d", checks);
    endtask

    task automatic test_ce_toggle();
        snap_t ea, eb;
        logic [3:0] ep;
        int lp_first, lp_second;
        reset_dut();
        lp_first = -1; lp_second = -1;
        for (int i = 0; i < 3200; i++) begin
            tick(i % 2 == 0, 1'b0);
            ea = q_a.pop_front(); eb = q_b.pop_front(); ep = qp.pop_front();
            checks++;
            if (dut_snap_a() !== ea || dut_snap_b() !== eb || obs_p !== ep) begin
                failures++;
                $display("FAIL ce_step i=%0d a=%h/%h b=%h/%h p=%b/%b",
                         i, dut_snap_a(), ea, dut_snap_b(), eb, obs_p, ep);
            end
            if (obs_p[3]) begin
                if (lp_first < 0) lp_first = i;
                else if (lp_second < 0) lp_second = i;
            end
            if (failures > 20) break;
        end
        checks++;
        if (lp_first != 1598 || lp_second - lp_first != 1600) begin
            failures++;
            $display("FAIL ce_line_period got first=%0d period=%0d exp first=1598 period=1600",
                     lp_first, lp_second - lp_first);
        end
        $display("test_ce_toggle done checks=%0d", checks);
    endtask

    task automatic test_small_config();
        snap_t ea, eb;
        logic [3:0] ep;
        int hs_cnt, hs_min, hs_max, vs_cnt, vs_min, vs_max, fp_cnt, fp_first, fp_last;
        reset_dut();
        hs_cnt = 0; hs_min = 99; hs_max = -1; vs_cnt = 0; vs_min = 99; vs_max = -1;
        fp_cnt = 0; fp_first = -1; fp_last = -1;
        for (int i = 0; i < 144; i++) begin
            tick(1'b0, 1'b1);
            ea = q_a.pop_front(); eb = q_b.pop_front(); ep = qp.pop_front();
            checks++;
            if (dut_snap_a() !== ea || dut_snap_b() !== eb || obs_p !== ep) begin
                failures++;
                $display("FAIL small_step i=%0d a=%h/%h b=%h/%h p=%b/%b",
                         i, dut_snap_a(), ea, dut_snap_b(), eb, obs_p, ep);
            end
            if (if_b.hsync === 1'b1) begin
                hs_cnt++;
                if (int'(if_b.hpos) < hs_min) hs_min = int'(if_b.hpos);
                if (int'(if_b.hpos) > hs_max) hs_max = int'(if_b.hpos);
            end
            if (if_b.vsync === 1'b1) begin
                vs_cnt++;
                if (int'(if_b.vpos) < vs_min) vs_min = int'(if_b.vpos);
                if (int'(if_b.vpos) > vs_max) vs_max = int'(if_b.vpos);
            end
            if (obs_p[0]) begin
                fp_cnt++;
                if (fp_first < 0) fp_first = i;
                fp_last = i;
            end
        end
        checks++;
        if (hs_cnt != 36 || hs_min != 5 || hs_max != 6) begin
            failures++;
            $display("FAIL small_hsync got cnt=%0d min=%0d max=%0d exp cnt=36 min=5 max=6",
                     hs_cnt, hs_min, hs_max);
        end
        checks++;
        if (vs_cnt != 24 || vs_min != 4 || vs_max != 4) begin
            failures++;
            $display("FAIL small_vsync got cnt=%0d min=%0d max=%0d exp cnt=24 min=4 max=4",
                     vs_cnt, vs_min, vs_max);
        end
        checks++;
        if (fp_cnt != 3 || fp_first != 47 || fp_last != 143) begin
            failures++;
            $display("FAIL small_frame_period got cnt=%0d first=%0d last=%0d exp cnt=3 first=47 last=143",
                     fp_cnt, fp_first, fp_last);
        end
        checks++;
        if (if_b.frame_count !== 8'd3) begin
            failures++;
            $display("FAIL small_frame_count got=%0d exp=3", if_b.frame_count);
        end
        $display("test_small_config done checks=%0d", checks);
    endtask

    task automatic test_reset_midframe();
        snap_t ea, eb;
        logic [3:0] ep;
        reset_dut();
        for (int i = 0; i < 1900; i++) begin
            tick(1'b1, 1'b0);
            ea = q_a.pop_front(); eb = q_b.pop_front(); ep = qp.pop_front();
            checks++;
            if (dut_snap_a() !== ea || dut_snap_b() !== eb || obs_p !== ep) begin
                failures++;
                $display("FAIL mid_step i=%0d a=%h/%h b=%h/%h p=%b/%b",
                         i, dut_snap_a(), ea, dut_snap_b(), eb, obs_p, ep);
            end
            if (failures > 20) break;
        end
        checks++;
        if (if_a.hpos !== 10'd300 || if_a.vpos !== 10'd2) begin
            failures++;
            $display("FAIL mid_position got=(%0d,%0d) exp=(300,2)", if_a.hpos, if_a.vpos);
        end
        // Pull reset between clock edges: outputs must change without waiting for an edge.
        if_a.ce = 1'b1;
        #2 nRst = 1'b0;
        #1;
        ea = snap_a(0, 0, 0);
        checks++;
        if (dut_snap_a() !== ea || if_a.line_pulse !== 1'b0) begin
            failures++;
            $display("FAIL mid_async_reset got=%h lp=%b exp=%h lp=0", dut_snap_a(), if_a.line_pulse, ea);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut_snap_a() !== ea) begin
            failures++;
            $display("FAIL mid_reset_hold got=%h exp=%h", dut_snap_a(), ea);
        end
        #1 nRst = 1'b1;
        model_reset();
        tick(1'b1, 1'b0);
        ea = q_a.pop_front(); eb = q_b.pop_front(); ep = qp.pop_front();
        checks++;
        if (dut_snap_a() !== ea || obs_p !== ep) begin
            failures++;
            $display("FAIL mid_first_tick got=%h p=%b exp=%h p=%b", dut_snap_a(), obs_p, ea, ep);
        end
        checks++;
        if (if_a.hpos !== 10'd1) begin
            failures++;
            $display("FAIL mid_hpos_after_release got=%0d exp=1", if_a.hpos);
        end
        $display("test_reset_midframe done checks=%0d", checks);
    endtask

    task automatic test_frame_wrap();
        snap_t ea, eb;
        logic [3:0] ep;
        int fp_cnt;
        reset_dut();
        fp_cnt = 0;
        for (int i = 0; i < 256 * 48; i++) begin
            tick(1'b0, 1'b1);
            ea = q_a.pop_front(); eb = q_b.pop_front(); ep = qp.pop_front();
            checks++;
            if (dut_snap_a() !== ea || dut_snap_b() !== eb || obs_p !== ep) begin
                failures++;
                $display("FAIL wrap_step i=%0d a=%h/%h b=%h/%h p=%b/%b",
                         i, dut_snap_a(), ea, dut_snap_b(), eb, obs_p, ep);
            end
            if (obs_p[0]) begin
                fp_cnt++;
                if (fp_cnt == 255) begin
                    checks++;
                    if (if_b.frame_count !== 8'd255) begin
                        failures++;
                        $display("FAIL wrap_count_255 got=%0d exp=255", if_b.frame_count);
                    end
                end
                if (fp_cnt == 256) begin
                    checks++;
                    if (if_b.frame_count !== 8'd0) begin
                        failures++;
                        $display("FAIL wrap_count_0 got=%0d exp=0", if_b.frame_count);
                    end
                end
            end
            if (failures > 20) break;
        end
        checks++;
        if (fp_cnt != 256) begin
            failures++;
            $display("FAIL wrap_pulse_count got=%0d exp=256", fp_cnt);
        end
        $display("test_frame_wrap done checks=%0d", checks);
    endtask

    task automatic test_fetch();
        snap_t ea, eb;
        logic [3:0] ep;
        int exp_fh_mid, exp_fa_mid, exp_fh_end, exp_fv_end, exp_fa_end;
`ifdef P09_VGA_TIMING_FETCH_EN
        exp_fh_mid = 640; exp_fa_mid = 0;
        exp_fh_end = 0;   exp_fv_end = 11; exp_fa_end = 1;
`else
        exp_fh_mid = 0; exp_fa_mid = 0;
        exp_fh_end = 0; exp_fv_end = 0; exp_fa_end = 0;
`endif
        reset_dut();
        for (int i = 0; i < 8798; i++) begin
            tick(1'b1, 1'b0);
            ea = q_a.pop_front(); eb = q_b.pop_front(); ep = qp.pop_front();
            checks++;
            if (dut_snap_a() !== ea || dut_snap_b() !== eb || obs_p !== ep) begin
                failures++;
                $display("FAIL fetch_step i=%0d a=%h/%h b=%h/%h p=%b/%b",
                         i, dut_snap_a(), ea, dut_snap_b(), eb, obs_p, ep);
            end
            if (i == 637) begin
                checks++;
                if (int'(if_a.fetch_hpos) != exp_fh_mid || int'(if_a.fetch_active) != exp_fa_mid
                    || if_a.hpos !== 10'd638) begin
                    failures++;
                    $display("FAIL fetch_at_638 got hpos=%0d fh=%0d fa=%b exp hpos=638 fh=%0d fa=%0d",
                             if_a.hpos, if_a.fetch_hpos, if_a.fetch_active, exp_fh_mid, exp_fa_mid);
                end
            end
            if (failures > 20) break;
        end
        checks++;
        if (if_a.hpos !== 10'd798 || if_a.vpos !== 10'd10 ||
            int'(if_a.fetch_hpos) != exp_fh_end || int'(if_a.fetch_vpos) != exp_fv_end ||
            int'(if_a.fetch_active) != exp_fa_end) begin
            failures++;
            $display("FAIL fetch_line_wrap got pos=(%0d,%0d) fetch=(%0d,%0d,%b) exp pos=(798,10) fetch=(%0d,%0d,%0d)",
                     if_a.hpos, if_a.vpos, if_a.fetch_hpos, if_a.fetch_vpos, if_a.fetch_active,
                     exp_fh_end, exp_fv_end, exp_fa_end);
        end
        $display("test_fetch done checks=%0d", checks);
    endtask

    initial begin
        test_reset();
        test_line_default();
        test_ce_toggle();
        test_small_config();
        test_reset_midframe();
        test_frame_wrap();
        test_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached at tick=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
